vga_pong_render: RTL

//  Pixel stage directly downstream of the 640x480 VGA sync/counter block. Consumes pos_H/pos_V,
//  vga_Ready, HSync and VSync; owns a bouncing ball and a button-driven left paddle, updated

---
 rtl/vga_pkg.sv | 16 +
 rtl/pong_object_update.sv | 94 +++++++++
 rtl/vga_pong_render.sv | 94 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, colours and shared types for the pong renderer
package vga_pkg;
  localparam int H_ACT_START = 144;
  localparam int V_ACT_START = 34;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int H_LAST = 799;
  localparam int V_LAST = 524;
  localparam logic [11:0] COL_BALL = 12'hFFF;
  localparam logic [11:0] COL_PAD = 12'h0F0;
  localparam logic [11:0] COL_BG = 12'h002;
  localparam logic [11:0] COL_OFF = 12'h000;
  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_e;
endpackage

// File: rtl/pong_object_update.sv
// pong_object_update: per-frame ball, paddle and miss-counter state, advanced only on frame_tick
module pong_object_update
  import vga_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int BALL_SPEED = 2,
  parameter int PAD_W = 8,
  parameter int PAD_H = 64,
  parameter int PAD_SPEED = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       up,
  input  logic       down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_y,
  output logic [3:0] miss_count
);
  localparam logic [9:0] BS = 10'(BALL_SIZE);
  localparam logic [9:0] BV = 10'(BALL_SPEED);
  localparam logic [9:0] PW = 10'(PAD_W);
  localparam logic [9:0] PH = 10'(PAD_H);
  localparam logic [9:0] PV = 10'(PAD_SPEED);
  localparam logic [9:0] X_MAX = 10'(H_ACT - BALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACT - BALL_SIZE);
  localparam logic [9:0] PAD_MAX = 10'(V_ACT - PAD_H);
  localparam logic [9:0] PAD_Y0 = 10'((V_ACT - PAD_H) / 2);
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d, pad_y_q, pad_y_d;
  dir_e dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [3:0] miss_q, miss_d;
  logic overlap, at_left, at_right, at_top, at_bottom, miss;
  always_comb begin
    overlap = (ball_y_q + BS > pad_y_q) && (ball_y_q < pad_y_q + PH);
    at_left = ball_x_q <= PW + BV;
    at_right = ball_x_q >= X_MAX - BV;
    at_top = ball_y_q <= BV;
    at_bottom = ball_y_q >= Y_MAX - BV;
    miss = (dir_x_q == DIR_NEG) && at_left && !overlap;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    pad_y_d = pad_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    miss_d = miss_q;
    if (frame_tick) begin
      pad_y_d = (up && !down) ? ((pad_y_q >= PV) ? pad_y_q - PV : '0)
              : (down && !up) ? ((pad_y_q >= PAD_MAX - PV) ? PAD_MAX : pad_y_q + PV)
              : pad_y_q;
      if (dir_x_q == DIR_POS) begin
        ball_x_d = at_right ? X_MAX : ball_x_q + BV;
        dir_x_d = at_right ? DIR_NEG : DIR_POS;
      end else begin
        ball_x_d = !at_left ? ball_x_q - BV : overlap ? PW : BALL_X0;
        dir_x_d = at_left ? DIR_POS : DIR_NEG;
      end
      if (dir_y_q == DIR_POS) begin
        ball_y_d = at_bottom ? Y_MAX : ball_y_q + BV;
        dir_y_d = at_bottom ? DIR_NEG : DIR_POS;
      end else begin
        ball_y_d = at_top ? '0 : ball_y_q - BV;
        dir_y_d = at_top ? DIR_POS : DIR_NEG;
      end
      // a miss recentres the ball, which overrides this tick's vertical step and bounce
      if (miss) begin
        ball_y_d = BALL_Y0;
        dir_y_d = dir_y_q;
        miss_d = miss_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x_q <= BALL_X0;
      ball_y_q <= BALL_Y0;
      pad_y_q <= PAD_Y0;
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
      miss_q <= '0;
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      pad_y_q <= pad_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      miss_q <= miss_d;
    end
  end
  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign pad_y = pad_y_q;
  assign miss_count = miss_q;
endmodule

// File: rtl/vga_pong_render.sv
// vga_pong_render: two-stage pixel pipeline drawing ball and paddle, with syncs delayed to stay aligned
module vga_pong_render
  import vga_pkg::*;
#(
  parameter int BALL_SIZE = 8,
  parameter int BALL_SPEED = 2,
  parameter int PAD_W = 8,
  parameter int PAD_H = 64,
  parameter int PAD_SPEED = 4
) (
  input  logic       vga_CLK,
  input  logic       vga_RST,
  input  logic [9:0] pos_H,
  input  logic [9:0] pos_V,
  input  logic       vga_Ready,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       btn_Up,
  input  logic       btn_Down,
  output logic [3:0] vga_R,
  output logic [3:0] vga_G,
  output logic [3:0] vga_B,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic [3:0] miss_Count
);
  localparam logic [9:0] BS = 10'(BALL_SIZE);
  localparam logic [9:0] PW = 10'(PAD_W);
  localparam logic [9:0] PH = 10'(PAD_H);
  logic [1:0] btn_up_q, btn_up_d, btn_dn_q, btn_dn_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic rdy_q, rdy_d, hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0] ball_x, ball_y, pad_y;
  logic [3:0] miss_count;
  logic frame_tick, in_ball, in_pad;
  always_comb begin
    frame_tick = (pos_H == 10'(H_LAST)) && (pos_V == 10'(V_LAST));
    btn_up_d = {btn_up_q[0], btn_Up};
    btn_dn_d = {btn_dn_q[0], btn_Down};
    x_d = pos_H - 10'(H_ACT_START);
    y_d = pos_V - 10'(V_ACT_START);
    rdy_d = vga_Ready;
    hs1_d = HSync_in;
    vs1_d = VSync_in;
    in_ball = (x_q >= ball_x) && (x_q < ball_x + BS) && (y_q >= ball_y) && (y_q < ball_y + BS);
    in_pad = (x_q < PW) && (y_q >= pad_y) && (y_q < pad_y + PH);
    rgb_d = !rdy_q ? COL_OFF : in_ball ? COL_BALL : in_pad ? COL_PAD : COL_BG;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end
  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) begin
      btn_up_q <= '0;
      btn_dn_q <= '0;
      x_q <= '0;
      y_q <= '0;
      rdy_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      rgb_q <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      btn_up_q <= btn_up_d;
      btn_dn_q <= btn_dn_d;
      x_q <= x_d;
      y_q <= y_d;
      rdy_q <= rdy_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      rgb_q <= rgb_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
    end
  end
  pong_object_update #(
    .BALL_SIZE(BALL_SIZE), .BALL_SPEED(BALL_SPEED), .PAD_W(PAD_W), .PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED)
  ) u_obj (
    .clk(vga_CLK),
    .rst(vga_RST),
    .frame_tick(frame_tick),
    .up(btn_up_q[1]),
    .down(btn_dn_q[1]),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .pad_y(pad_y),
    .miss_count(miss_count)
  );
  assign {vga_R, vga_G, vga_B} = rgb_q;
  assign HSync_out = hs2_q;
  assign VSync_out = vs2_q;
  assign miss_Count = miss_count;
endmodule
